// File: rtl/life_gen_sequencer.sv
// rtl/life_gen_sequencer.sv - Game-of-Life generation sequencer over a double-buffered cell RAM
module life_gen_sequencer #(
  parameter int         W       = 160,
  parameter int         H       = 120,
  parameter int         ADDR_W  = 15,
  parameter logic [2:0] ALIVE_C = 3'b111,
  parameter logic [2:0] DEAD_C  = 3'b000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              run,
  input  logic              load,
  input  logic [7:0]        load_x,
  input  logic [6:0]        load_y,
  input  logic              clear,
  output logic              busy,
  output logic              gen_done,
  output logic [15:0]       gen_count,
  output logic              front_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              plot_valid,
  input  logic              plot_ready,
  output logic [7:0]        plot_x,
  output logic [6:0]        plot_y,
  output logic [2:0]        plot_colour
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLR_WR = 3'd2,
    ST_SCAN   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_PLOT   = 3'd5,
    ST_SWAP   = 3'd6
  } state_t;

  // What the shared PLOT state returns to once the plotter accepts.
  typedef enum logic [1:0] {
    MODE_GEN  = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_CLR  = 2'd2
  } mode_t;

  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(W);
  localparam logic [3:0]        LAST_READ = 4'd8;
  localparam logic [3:0]        CENTRE_K  = 4'd4;
  localparam logic [3:0]        CAPTURE_K = 4'd9;

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  n_q, n_d;
  logic        alive_q, alive_d;
  logic        plot_alive_q, plot_alive_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_centre_q, rd_centre_d;
  logic        front_bank_q, front_bank_d;
  logic [15:0] gen_count_q, gen_count_d;

  logic [1:0]        off_x, off_y;
  logic [9:0]        nb_x, nb_y;
  logic              nb_in_grid;
  logic [ADDR_W-1:0] cell_addr, nb_addr;
  logic              last_x, last_cell;
  logic [7:0]        x_adv;
  logic [6:0]        y_adv;
  logic              next_alive;
  logic              load_in_range;

  // Neighbourhood read index k (0..8) mapped to raster-ordered offsets, stored as offset+1.
  always_comb begin
    case (k_q)
      4'd1, 4'd4, 4'd7: off_x = 2'd1;
      4'd2, 4'd5, 4'd8: off_x = 2'd2;
      default:          off_x = 2'd0;
    endcase
    case (k_q)
      4'd3, 4'd4, 4'd5: off_y = 2'd1;
      4'd6, 4'd7, 4'd8: off_y = 2'd2;
      default:          off_y = 2'd0;
    endcase
  end

  // A -1 offset at the edge wraps to a huge unsigned value, so one compare covers both sides.
  assign nb_x          = {2'b00, x_q} + {8'b0, off_x} - 10'd1;
  assign nb_y          = {3'b000, y_q} + {8'b0, off_y} - 10'd1;
  assign nb_in_grid    = (int'(nb_x) < W) && (int'(nb_y) < H);
  assign nb_addr       = ADDR_W'(nb_y) * W_A + ADDR_W'(nb_x);
  assign cell_addr     = ADDR_W'(y_q) * W_A + ADDR_W'(x_q);
  assign last_x        = (int'(x_q) == W - 1);
  assign last_cell     = last_x && (int'(y_q) == H - 1);
  assign x_adv         = last_x ? 8'd0 : x_q + 8'd1;
  assign y_adv         = last_x ? y_q + 7'd1 : y_q;
  assign next_alive    = (n_q == 4'd3) || (alive_q && (n_q == 4'd2));
  assign load_in_range = (int'(load_x) < W) && (int'(load_y) < H);

  // State register and datapath flops; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_GEN;
      x_q          <= '0;
      y_q          <= '0;
      k_q          <= '0;
      n_q          <= '0;
      alive_q      <= 1'b0;
      plot_alive_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_centre_q  <= 1'b0;
      front_bank_q <= 1'b0;
      gen_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      x_q          <= x_d;
      y_q          <= y_d;
      k_q          <= k_d;
      n_q          <= n_d;
      alive_q      <= alive_d;
      plot_alive_q <= plot_alive_d;
      rd_valid_q   <= rd_valid_d;
      rd_centre_q  <= rd_centre_d;
      front_bank_q <= front_bank_d;
      gen_count_q  <= gen_count_d;
    end
  end

  // Next state: command decode in IDLE, cell walk, neighbour accumulation and bank swap.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    x_d          = x_q;
    y_d          = y_q;
    k_d          = k_q;
    n_d          = n_q;
    alive_d      = alive_q;
    plot_alive_d = plot_alive_q;
    rd_valid_d   = 1'b0;
    rd_centre_d  = 1'b0;
    front_bank_d = front_bank_q;
    gen_count_d  = gen_count_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          mode_d  = MODE_CLR;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_CLR_WR;
        end else if (load) begin
          if (load_in_range) begin
            mode_d  = MODE_LOAD;
            x_d     = load_x;
            y_d     = load_y;
            state_d = ST_LOAD;
          end
        end else if (start || run) begin
          mode_d  = MODE_GEN;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          state_d = ST_SCAN;
        end
      end
      ST_LOAD: begin
        plot_alive_d = 1'b1;
        state_d      = ST_PLOT;
      end
      ST_CLR_WR: begin
        plot_alive_d = 1'b0;
        state_d      = ST_PLOT;
      end
      ST_SCAN: begin
        // The valid/centre tags travel one cycle behind the address, matching RAM latency.
        rd_valid_d  = (k_q <= LAST_READ) && nb_in_grid;
        rd_centre_d = (k_q == CENTRE_K);
        if (k_q == 4'd0) begin
          n_d     = '0;
          alive_d = 1'b0;
        end else if (rd_valid_q) begin
          if (rd_centre_q) alive_d = rd_data;
          else             n_d     = n_q + {3'b000, rd_data};
        end
        if (k_q == CAPTURE_K) state_d = ST_UPDATE;
        else                  k_d     = k_q + 4'd1;
      end
      ST_UPDATE: begin
        plot_alive_d = next_alive;
        if (next_alive != alive_q) begin
          state_d = ST_PLOT;
        end else if (last_cell) begin
          state_d = ST_SWAP;
        end else begin
          x_d     = x_adv;
          y_d     = y_adv;
          k_d     = '0;
          state_d = ST_SCAN;
        end
      end
      ST_PLOT: begin
        if (plot_ready) begin
          case (mode_q)
            MODE_LOAD: state_d = ST_IDLE;
            MODE_CLR: begin
              if (last_cell) begin
                state_d = ST_IDLE;
              end else begin
                x_d     = x_adv;
                y_d     = y_adv;
                state_d = ST_CLR_WR;
              end
            end
            default: begin
              if (last_cell) begin
                state_d = ST_SWAP;
              end else begin
                x_d     = x_adv;
                y_d     = y_adv;
                k_d     = '0;
                state_d = ST_SCAN;
              end
            end
          endcase
        end
      end
      ST_SWAP: begin
        front_bank_d = ~front_bank_q;
        gen_count_d  = gen_count_q + 16'd1;
        if (run) begin
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; idle values are all zero.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    gen_done    = (state_q == ST_SWAP);
    gen_count   = gen_count_q;
    front_bank  = front_bank_q;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_bank     = 1'b0;
    wr_addr     = '0;
    wr_data     = 1'b0;
    plot_valid  = 1'b0;
    plot_x      = '0;
    plot_y      = '0;
    plot_colour = '0;
    case (state_q)
      ST_SCAN: begin
        if (k_q <= LAST_READ) rd_addr = nb_in_grid ? nb_addr : cell_addr;
      end
      ST_LOAD: begin
        wr_en   = 1'b1;
        wr_bank = front_bank_q;
        wr_addr = cell_addr;
        wr_data = 1'b1;
      end
      ST_CLR_WR: begin
        wr_en   = 1'b1;
        wr_bank = front_bank_q;
        wr_addr = cell_addr;
        wr_data = 1'b0;
      end
      ST_UPDATE: begin
        wr_en   = 1'b1;
        wr_bank = ~front_bank_q;
        wr_addr = cell_addr;
        wr_data = next_alive;
      end
      ST_PLOT: begin
        plot_valid  = 1'b1;
        plot_x      = x_q;
        plot_y      = y_q;
        plot_colour = plot_alive_q ? ALIVE_C : DEAD_C;
      end
      default: ;
    endcase
  end

endmodule
